// File: rtl/fuzzy_heater_pkg.sv
// Shared constants for the fuzzy heater array: vote codes, duty percentages, trip FSM states.
// No logic, no latency, no backpressure.
package fuzzy_heater_pkg;

   // Sign-magnitude heat-feeling votes: bit 2 is the sign, so "cold" votes ask for more heat
   localparam logic [2:0] FEEL_ZERO = 3'b000;
   localparam logic [2:0] FEEL_P1   = 3'b001;
   localparam logic [2:0] FEEL_P2   = 3'b010;
   localparam logic [2:0] FEEL_P3   = 3'b011;
   localparam logic [2:0] FEEL_INV  = 3'b100;
   localparam logic [2:0] FEEL_N1   = 3'b101;
   localparam logic [2:0] FEEL_N2   = 3'b110;
   localparam logic [2:0] FEEL_N3   = 3'b111;

   localparam int PCT_0   = 0;
   localparam int PCT_25  = 25;
   localparam int PCT_50  = 50;
   localparam int PCT_75  = 75;
   localparam int PCT_100 = 100;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_TRIP   = 1'b1
   } heater_state_e;

   // Floored pct * (2^pwm_w - 1) / 100
   function automatic int pct_to_duty(input int pct, input int pwm_w);
      return (pct * ((1 << pwm_w) - 1)) / 100;
   endfunction

endpackage

// File: rtl/fuzzy_heater_channel.sv
// One heater channel: vote decode, slewed duty, over-temp trip with hysteresis, frame-aligned PWM.
// Trip 1 cycle after the temperature register, PWM output 1 cycle after compare; no backpressure.
module fuzzy_heater_channel
   import fuzzy_heater_pkg::*;
#(
   parameter int          PWM_W      = 8,
   parameter int          SLEW_STEP  = 16,
   parameter logic [15:0] TEMP_LIMIT = 16'd4500,
   parameter logic [15:0] TEMP_HYST  = 16'd300
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [15:0]      temp_i,
   input  logic [2:0]       feel_i,
   input  logic             tick_i,
   input  logic             frame_start_i,
   input  logic [PWM_W-1:0] pwm_cnt_i,
   output logic             pwm_o,
   output logic [PWM_W-1:0] duty_o,
   output logic             over_temp_o
);

   localparam int             DMAX   = (1 << PWM_W) - 1;
   localparam int             STEP_I = (SLEW_STEP > DMAX) ? DMAX : SLEW_STEP;
   localparam logic [PWM_W:0] STEP   = (PWM_W+1)'(STEP_I);
   localparam logic [15:0]    REARM  = TEMP_LIMIT - TEMP_HYST;

   localparam logic [PWM_W-1:0] TGT_0   = PWM_W'(pct_to_duty(PCT_0,   PWM_W));
   localparam logic [PWM_W-1:0] TGT_25  = PWM_W'(pct_to_duty(PCT_25,  PWM_W));
   localparam logic [PWM_W-1:0] TGT_50  = PWM_W'(pct_to_duty(PCT_50,  PWM_W));
   localparam logic [PWM_W-1:0] TGT_75  = PWM_W'(pct_to_duty(PCT_75,  PWM_W));
   localparam logic [PWM_W-1:0] TGT_100 = PWM_W'(pct_to_duty(PCT_100, PWM_W));

   logic [15:0]      temp_q;
   heater_state_e    state_q, state_d;
   logic [PWM_W-1:0] cur_q, cur_d;
   logic [PWM_W-1:0] frame_q, frame_d;
   logic             pwm_q, pwm_d;
   logic [PWM_W-1:0] tgt;
   logic [PWM_W-1:0] frame_eff;
   logic [PWM_W:0]   cur_x, tgt_x, up_x, dn_x;

   always_comb begin
      tgt = TGT_0;
      case (feel_i)
         FEEL_P1:                               tgt = TGT_25;
         FEEL_N1:                               tgt = TGT_50;
         FEEL_N2:                               tgt = TGT_75;
         FEEL_N3:                               tgt = TGT_100;
         FEEL_P3, FEEL_P2, FEEL_ZERO, FEEL_INV: tgt = TGT_0;
         default:                               tgt = TGT_0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_NORMAL: if (temp_q >= TEMP_LIMIT) state_d = ST_TRIP;
         ST_TRIP:   if (temp_q < REARM)       state_d = ST_NORMAL;
         default:   state_d = ST_NORMAL;
      endcase
   end

   // One extra bit keeps cur+STEP from wrapping past DMAX
   assign cur_x = {1'b0, cur_q};
   assign tgt_x = {1'b0, tgt};
   assign up_x  = cur_x + STEP;
   assign dn_x  = cur_x - STEP;

   // The trip path is checked first so it overrides a coincident tick
   always_comb begin
      cur_d = cur_q;
      if (state_d == ST_TRIP) begin
         cur_d = '0;
      end else if (tick_i) begin
         if (cur_x < tgt_x) begin
            cur_d = (up_x >= tgt_x) ? tgt : up_x[PWM_W-1:0];
         end else if (cur_x > tgt_x) begin
            cur_d = (cur_x >= tgt_x + STEP) ? dn_x[PWM_W-1:0] : tgt;
         end
      end
   end

   // At frame start the compare already uses the newly latched duty, so each frame's
   // high time equals the duty captured at its start
   assign frame_eff = frame_start_i ? cur_q : frame_q;
   assign frame_d   = (state_d == ST_TRIP) ? '0 : frame_eff;
   assign pwm_d     = (state_q == ST_NORMAL) && (pwm_cnt_i < frame_eff);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         temp_q  <= '0;
         state_q <= ST_NORMAL;
         cur_q   <= '0;
         frame_q <= '0;
         pwm_q   <= 1'b0;
      end else begin
         temp_q  <= temp_i;
         state_q <= state_d;
         cur_q   <= cur_d;
         frame_q <= frame_d;
         pwm_q   <= pwm_d;
      end
   end

   assign pwm_o       = pwm_q;
   assign duty_o      = cur_q;
   assign over_temp_o = (state_q == ST_TRIP);

endmodule

// File: rtl/fuzzy_heater_array.sv
// Multi-channel fuzzy heater controller: shared update prescaler and PWM frame counter, NUM_CH channels.
// Duty slews once per Update_Tick, PWM registered one cycle after compare; no backpressure.
module fuzzy_heater_array
   import fuzzy_heater_pkg::*;
#(
   parameter int          NUM_CH     = 2,
   parameter int          PWM_W      = 8,
   parameter int          CLK_HZ     = 50000000,
   parameter int          UPDATE_HZ  = 2,
   parameter int          SLEW_STEP  = 16,
   parameter logic [15:0] TEMP_LIMIT = 16'd4500,
   parameter logic [15:0] TEMP_HYST  = 16'd300
) (
   input  logic                      CLOCK_50,
   input  logic                      RESET_N,
   input  logic [16*NUM_CH-1:0]      Real_Temperature,
   input  logic [3*NUM_CH-1:0]       Heat_Feeling,
   output logic [NUM_CH-1:0]         PWM_Heater,
   output logic [PWM_W*NUM_CH-1:0]   Duty_Applied,
   output logic [NUM_CH-1:0]         Over_Temp,
   output logic                      Update_Tick
);

   localparam int               DIV      = CLK_HZ / UPDATE_HZ;
   localparam int               PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'((1 << PWM_W) - 2);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [PWM_W-1:0] cnt_q, cnt_d;
   logic             tick;
   logic             frame_start;

   assign tick        = (pre_q == PRE_LAST);
   assign frame_start = (cnt_q == '0);
   assign pre_d       = tick ? '0 : pre_q + PRE_W'(1);
   assign cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + PWM_W'(1);

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
      end
   end

   assign Update_Tick = tick;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      fuzzy_heater_channel #(
         .PWM_W      (PWM_W),
         .SLEW_STEP  (SLEW_STEP),
         .TEMP_LIMIT (TEMP_LIMIT),
         .TEMP_HYST  (TEMP_HYST)
      ) u_ch (
         .clk_i         (CLOCK_50),
         .rst_ni        (RESET_N),
         .temp_i        (Real_Temperature[16*i +: 16]),
         .feel_i        (Heat_Feeling[3*i +: 3]),
         .tick_i        (tick),
         .frame_start_i (frame_start),
         .pwm_cnt_i     (cnt_q),
         .pwm_o         (PWM_Heater[i]),
         .duty_o        (Duty_Applied[PWM_W*i +: PWM_W]),
         .over_temp_o   (Over_Temp[i])
      );
   end

endmodule

// File: tb/tb_fuzzy_heater_array.sv
// Bench for fuzzy_heater_array: directed sequences, a decode table, and a randomized run
// checked against a cycle-level arithmetic model of the slew/trip/PWM rules.
module tb_fuzzy_heater_array;

   localparam int NCH   = 2;
   localparam int PW    = 8;
   localparam int DMAX  = 255;
   localparam int SLEW  = 64;
   localparam int DIV   = 10;
   localparam int LIMIT = 4500;
   localparam int REARM = 4200;

   logic             CLOCK_50 = 1'b0;
   logic             RESET_N;
   logic [16*NCH-1:0] Real_Temperature;
   logic [3*NCH-1:0]  Heat_Feeling;
   logic [NCH-1:0]    PWM_Heater;
   logic [PW*NCH-1:0] Duty_Applied;
   logic [NCH-1:0]    Over_Temp;
   logic              Update_Tick;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   fuzzy_heater_array #(
      .NUM_CH(NCH), .PWM_W(PW), .CLK_HZ(1000), .UPDATE_HZ(100), .SLEW_STEP(SLEW),
      .TEMP_LIMIT(16'd4500), .TEMP_HYST(16'd300)
   ) dut (
      .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .Real_Temperature(Real_Temperature),
      .Heat_Feeling(Heat_Feeling), .PWM_Heater(PWM_Heater), .Duty_Applied(Duty_Applied),
      .Over_Temp(Over_Temp), .Update_Tick(Update_Tick)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   function automatic int duty(input int c);
      return int'(Duty_Applied[c*PW +: PW]);
   endfunction

   task automatic set_vote(input int c, input logic [2:0] v);
      Heat_Feeling[c*3 +: 3] = v;
   endtask

   task automatic set_temp(input int c, input int t);
      Real_Temperature[c*16 +: 16] = 16'(t);
   endtask

   function automatic int target_of(input logic [2:0] v);
      int pct;
      case (v)
         3'b001:  pct = 25;
         3'b101:  pct = 50;
         3'b110:  pct = 75;
         3'b111:  pct = 100;
         default: pct = 0;
      endcase
      return pct * DMAX / 100;
   endfunction

   // Leaves the caller at the negedge of the cycle in which Update_Tick is high
   task automatic wait_tick();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge CLOCK_50);
         if (Update_Tick) seen = 1'b1;
      end
      if (!seen) check("tick_timeout", 0, 1);
   endtask

   // n update ticks, then one more cycle so the last update is visible
   task automatic ticks(input int n);
      repeat (n) wait_tick();
      @(negedge CLOCK_50);
   endtask

   task automatic count_high(input int n, output int h0, output int h1);
      h0 = 0;
      h1 = 0;
      repeat (n) begin
         @(negedge CLOCK_50);
         h0 += int'(PWM_Heater[0]);
         h1 += int'(PWM_Heater[1]);
      end
   endtask

   function automatic int rand_temp();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) return $urandom_range(0, 4000);
      if (r < 9) return $urandom_range(4150, 4550);
      return $urandom_range(4500, 8000);
   endfunction

   // ---------------- reference model ----------------
   int m_pre, m_cnt;
   int m_cur [NCH];
   int m_temp[NCH];
   bit m_trip[NCH];

   function automatic void model_reset();
      m_pre = 0;
      m_cnt = 0;
      for (int c = 0; c < NCH; c++) begin
         m_cur[c] = 0; m_temp[c] = 0; m_trip[c] = 1'b0;
      end
   endfunction

   function automatic void model_step();
      for (int c = 0; c < NCH; c++) begin
         bit hot;
         int tgt;
         hot = m_trip[c] ? (m_temp[c] >= REARM) : (m_temp[c] >= LIMIT);
         tgt = target_of(Heat_Feeling[c*3 +: 3]);
         if (hot) m_cur[c] = 0;
         else if (m_pre == DIV - 1) begin
            if (m_cur[c] < tgt)      m_cur[c] = (m_cur[c] + SLEW < tgt) ? m_cur[c] + SLEW : tgt;
            else if (m_cur[c] > tgt) m_cur[c] = (m_cur[c] - SLEW > tgt) ? m_cur[c] - SLEW : tgt;
         end
         m_trip[c] = hot;
         m_temp[c] = int'(Real_Temperature[c*16 +: 16]);
      end
      m_pre = (m_pre + 1) % DIV;
      m_cnt = (m_cnt + 1) % DMAX;
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge CLOCK_50 or negedge RESET_N);
         if (!RESET_N) model_reset();
         else model_step();
      end
   end

   // Random-phase checker: per-cycle duty/trip/tick plus per-frame PWM high time
   int w_acc[NCH], w_exp[NCH], w_lat[NCH];
   bit w_ok[NCH], w_have[NCH];

   initial begin
      for (int c = 0; c < NCH; c++) begin
         w_acc[c] = 0; w_exp[c] = 0; w_lat[c] = 0; w_ok[c] = 1'b0; w_have[c] = 1'b0;
      end
      forever begin
         @(negedge CLOCK_50);
         if (chk_en) begin
            check("rnd_tick", int'(Update_Tick), (m_pre == DIV - 1) ? 1 : 0);
            for (int c = 0; c < NCH; c++) begin
               check("rnd_duty", duty(c), m_cur[c]);
               check("rnd_over_temp", int'(Over_Temp[c]), int'(m_trip[c]));
               if (m_cnt == 1) begin
                  if (w_ok[c]) check("rnd_frame_high", w_acc[c], w_exp[c]);
                  w_acc[c]  = 0;
                  w_exp[c]  = w_lat[c];
                  w_ok[c]   = w_have[c];
                  w_have[c] = 1'b0;
               end
               w_acc[c] += int'(PWM_Heater[c]);
               if (m_trip[c]) w_ok[c] = 1'b0;
               if (m_cnt == 0) begin
                  w_lat[c]  = m_cur[c];
                  w_have[c] = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0] feel;
      int         exp;
   } vec_t;

   initial begin
      vec_t tbl[8];
      int   hi, hi2, h0, h1;
      int   down_exp[4];

      tbl[0] = '{3'b111, 255}; tbl[1] = '{3'b011, 0};
      tbl[2] = '{3'b110, 191}; tbl[3] = '{3'b000, 0};
      tbl[4] = '{3'b101, 127}; tbl[5] = '{3'b100, 0};
      tbl[6] = '{3'b001, 63};  tbl[7] = '{3'b010, 0};
      down_exp = '{191, 127, 63, 0};

      RESET_N          = 1'b0;
      Heat_Feeling     = {3'b111, 3'b111};
      Real_Temperature = {16'd2000, 16'd2000};
      repeat (3) @(negedge CLOCK_50);
      check("rst_pwm", int'(PWM_Heater), 0);
      check("rst_duty", int'(Duty_Applied), 0);
      check("rst_over_temp", int'(Over_Temp), 0);
      check("rst_tick", int'(Update_Tick), 0);

      // Step up on ch0 with frame-by-frame PWM high time
      Heat_Feeling = {3'b000, 3'b111};
      RESET_N      = 1'b1;
      hi  = 0;
      hi2 = 0;
      for (int j = 1; j <= 510; j++) begin
         @(negedge CLOCK_50);
         if (j == 9)  check("first_tick", int'(Update_Tick), 1);
         if (j == 10) check("step_up_1", duty(0), 64);
         if (j == 20) check("step_up_2", duty(0), 128);
         if (j == 30) check("step_up_3", duty(0), 192);
         if (j == 40) check("step_up_4", duty(0), 255);
         if (j <= 255) hi += int'(PWM_Heater[0]);
         else          hi2 += int'(PWM_Heater[0]);
      end
      check("frame0_high", hi, 0);
      check("frame1_high", hi2, 255);

      // Extremes across two frames
      count_high(510, h0, h1);
      check("duty255_const_high", h0, 510);
      check("duty0_never_high", h1, 0);

      // Asynchronous reset mid-frame
      check("pre_reset_pwm", int'(PWM_Heater[0]), 1);
      #2 RESET_N = 1'b0;
      #1;
      check("async_reset_pwm", int'(PWM_Heater), 0);
      check("async_reset_duty", int'(Duty_Applied), 0);
      @(negedge CLOCK_50);
      Heat_Feeling = {3'b111, 3'b111};
      RESET_N      = 1'b1;

      ticks(4);
      check("both_full_ch0", duty(0), 255);
      check("both_full_ch1", duty(1), 255);

      // Step down via invalid code, then +1 from zero
      set_vote(1, 3'b100);
      for (int k = 0; k < 4; k++) begin
         ticks(1);
         check("step_down", duty(1), down_exp[k]);
      end
      set_vote(1, 3'b001);
      ticks(1);
      check("plus1_from_zero", duty(1), 63);

      // Vote decode table, settled values
      for (int k = 0; k < 8; k++) begin
         set_vote(0, tbl[k].feel);
         set_vote(1, tbl[k].feel);
         ticks(5);
         check("decode_ch0", duty(0), tbl[k].exp);
         check("decode_ch1", duty(1), tbl[k].exp);
      end

      // Over-temperature trip, hysteresis and re-arm on ch0
      set_vote(0, 3'b111);
      ticks(5);
      repeat (260) @(negedge CLOCK_50);
      wait_tick();
      @(negedge CLOCK_50);
      set_temp(0, 4500);
      @(negedge CLOCK_50);
      check("trip_n_over_temp", int'(Over_Temp[0]), 0);
      check("trip_n_pwm", int'(PWM_Heater[0]), 1);
      @(negedge CLOCK_50);
      check("trip_n1_over_temp", int'(Over_Temp[0]), 1);
      check("trip_n1_duty", duty(0), 0);
      check("trip_n1_pwm", int'(PWM_Heater[0]), 1);
      check("trip_n1_ch1_free", int'(Over_Temp[1]), 0);
      @(negedge CLOCK_50);
      check("trip_n2_pwm", int'(PWM_Heater[0]), 0);
      set_temp(0, 4200);
      repeat (30) @(negedge CLOCK_50);
      check("hyst_hold_over_temp", int'(Over_Temp[0]), 1);
      check("hyst_hold_duty", duty(0), 0);
      check("hyst_hold_pwm", int'(PWM_Heater[0]), 0);
      wait_tick();
      @(negedge CLOCK_50);
      set_temp(0, 4199);
      @(negedge CLOCK_50);
      check("rearm_n_over_temp", int'(Over_Temp[0]), 1);
      @(negedge CLOCK_50);
      check("rearm_n1_over_temp", int'(Over_Temp[0]), 0);
      ticks(1);
      check("rearm_climb_1", duty(0), 64);
      ticks(1);
      check("rearm_climb_2", duty(0), 128);

      // Independence: ch0 tripped while ch1 runs
      set_temp(0, 5000);
      set_vote(1, 3'b110);
      ticks(4);
      check("indep_ch1_duty", duty(1), 191);
      check("indep_ch0_over_temp", int'(Over_Temp[0]), 1);
      check("indep_ch0_duty", duty(0), 0);
      check("indep_ch1_over_temp", int'(Over_Temp[1]), 0);
      repeat (260) @(negedge CLOCK_50);
      count_high(255, h0, h1);
      check("indep_ch1_high", h1, 191);
      check("indep_ch0_high", h0, 0);

      // Trip coinciding with an update tick on ch1
      wait_tick();
      @(negedge CLOCK_50);
      set_vote(1, 3'b111);
      repeat (8) @(negedge CLOCK_50);
      set_temp(1, 4600);
      @(negedge CLOCK_50);
      check("coinc_tick", int'(Update_Tick), 1);
      check("coinc_before_over_temp", int'(Over_Temp[1]), 0);
      check("coinc_before_duty", duty(1), 191);
      @(negedge CLOCK_50);
      check("coinc_over_temp", int'(Over_Temp[1]), 1);
      check("coinc_trip_wins_duty", duty(1), 0);

      // Randomized run against the model
      set_temp(0, 2000);
      set_temp(1, 2000);
      @(negedge CLOCK_50);
      RESET_N = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      RESET_N = 1'b1;
      chk_en  = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLOCK_50);
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 19) == 0) set_vote(c, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 59) == 0) set_temp(c, rand_temp());
         end
      end
      @(negedge CLOCK_50);
      chk_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fuzzy_heater_array.md
# fuzzy_heater_array

- Multi-channel successor to the two-user heater controller.
- Each channel maps a 3-bit heat-feeling vote to a target duty. The applied duty slews toward that target once per update tick.
- Each channel drives a PWM heater output with frame-aligned duty updates and a per-channel over-temperature trip with hysteresis.
- Sits between the sensor/feeling front-end and the heater driver pins on the DE10-Nano RFS sensor design.

## Interface
- `NUM_CH`, 2 — number of independent heater channels (1..16)
- `PWM_W`, 8 — PWM resolution; `DMAX = 2^PWM_W-1`
- `CLK_HZ`, 50000000 — CLOCK_50 frequency
- `UPDATE_HZ`, 2 — duty-slew update rate
- `SLEW_STEP`, 16 — maximum duty change per update tick, in counts (≥1)
- `TEMP_LIMIT`, 16'd4500 — trip threshold, same units as temperature input
- `TEMP_HYST`, 16'd300 — re-arm hysteresis (< TEMP_LIMIT)

Ports:
- `CLOCK_50` in 1 — sole clock
- `RESET_N` in 1 — asynchronous, active-low reset
- `Real_Temperature` in 16*NUM_CH — unsigned per-channel temperature; channel i at [16i+15:16i]
- `Heat_Feeling` in 3*NUM_CH — per-channel vote, sign-magnitude
- `PWM_Heater` out NUM_CH — heater drive, registered
- `Duty_Applied` out PWM_W*NUM_CH — current slewed duty per channel
- `Over_Temp` out NUM_CH — 1 while channel is tripped
- `Update_Tick` out 1 — one-cycle pulse at each update instant

## Operation
- Prescaler: free-running counter 0..`CLK_HZ/UPDATE_HZ-1`; `Update_Tick`=1 on the terminal count cycle. This is a clock enable, not a derived clock.
- Vote decode to target, with `pct*DMAX/100` floored:
  - 011 (+3) → 0
  - 010 (+2) → 0
  - 001 (+1) → 25%
  - 000 → 0
  - 101 (-1) → 50%
  - 110 (-2) → 75%
  - 111 (-3) → DMAX
  - 100 (invalid) → 0
  - For PWM_W=8 the non-zero targets are 63, 127, 191, 255.
- Slew: on `Update_Tick`, if cur<tgt then `cur = min(cur+SLEW_STEP, tgt)`; if cur>tgt then `cur = max(cur-SLEW_STEP, tgt)`.
  - Compute in PWM_W+1 bits; never wraps.
- PWM frame: shared counter 0..DMAX-1 (period DMAX cycles).
  - Each channel latches `cur` into its frame register when counter==0.
  - `PWM_Heater[i] = (counter < frame_duty[i])`. DMAX gives constant 1; 0 gives constant 0.
- Per-channel FSM:
  - NORMAL: goes to TRIP when registered temp ≥ TEMP_LIMIT.
  - TRIP: goes to NORMAL when registered temp < TEMP_LIMIT-TEMP_HYST.
  - In TRIP: `cur` and frame register forced 0, PWM forced 0 immediately (not frame-aligned), `Over_Temp`=1, slew suspended.
  - On leaving TRIP, `cur` restarts from 0 and slews up.
- Channels are fully independent except for the shared prescaler and PWM counter.

## Timing
- Reset (async assert, sync release) clears:
  - prescaler, PWM counter, all `cur` and frame registers, temp registers
  - FSM → NORMAL
  - `PWM_Heater`=0, `Duty_Applied`=0, `Over_Temp`=0, `Update_Tick`=0
- Reset asserted mid-frame drops all outputs to 0 asynchronously.
- Vote→`cur` latency: the vote is decoded combinationally. The first change lands on the next `Update_Tick` edge, with full effect after `ceil(|Δ|/SLEW_STEP)` ticks.
- `cur`→PWM latency: visible from the next frame start (counter==0), with one extra registered cycle on `PWM_Heater`.
- Trip latency:
  - Temperature registered in cycle N.
  - `Over_Temp` and forced-zero take effect in N+1.
  - `PWM_Heater`=0 in N+2.
- A temperature crossing in the same cycle as `Update_Tick` or a frame start: trip wins.
- Temperature exactly at TEMP_LIMIT trips; exactly at TEMP_LIMIT-TEMP_HYST stays tripped.

## Structure
- Package `fuzzy_heater_pkg`:
  - feeling code constants (`FEEL_P3`..`FEEL_N3`, `FEEL_INV`)
  - percent levels 0/25/50/75/100
  - FSM state enum `{ST_NORMAL, ST_TRIP}`
  - function `pct_to_duty(pct, PWM_W)`
- Sub-module `fuzzy_heater_channel` (decode, slew, trip FSM, frame register, PWM compare), instantiated NUM_CH times by generate.
- Prescaler and PWM counter stay in the top level.

## Test plan
All scenarios use CLK_HZ=1000, UPDATE_HZ=100 (tick every 10 cycles), PWM_W=8, SLEW_STEP=64.
- Reset: hold RESET_N=0, drive votes 111 → all outputs 0. Assert RESET_N mid-frame with PWM high → `PWM_Heater` drops to 0 without a clock edge.
- Step up: ch0 000→111, temp 2000 → `Duty_Applied[0]` 64, 128, 192, 255 on four successive ticks. PWM high-time per 255-cycle frame matches the value latched at that frame's start.
- Step down and invalid code: ch1 at 255, vote→100 → duty 191, 127, 63, 0. Code 001 from 0 settles at 63 after one tick.
- Over-temp: ch0 at 255, temp→4500 → `Over_Temp[0]`=1 at N+1, PWM 0 at N+2, duty 0.
  - Temp 4200 keeps TRIP; temp 4199 returns to NORMAL.
  - After re-arm, duty climbs 64, 128, … again.
- Independence: ch0 tripped, ch1 vote 110 → ch1 reaches 191 and PWMs normally. Simultaneous trip and tick on ch1 → trip wins, duty 0.
- Extremes: duty 0 → PWM never high across two frames; duty 255 → PWM constantly high across the frame boundary.
